// File: rtl/taillight_pkg.sv
// Shared tail-light definitions: state codes, request decode, sweep lengths.
// The LED output stage reuses state_e so both sides agree on the encoding.
package taillight_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'b000,
    HAZARDS    = 3'b001,
    TURN_LEFT  = 3'b010,
    TURN_RIGHT = 3'b011
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_HAZ  = 2'd1,
    REQ_L    = 2'd2,
    REQ_R    = 2'd3
  } req_e;

  localparam int unsigned PHASE_W = 2;

  // Last phase index of each pattern
  localparam logic [PHASE_W-1:0] TURN_LAST = 2'd3;
  localparam logic [PHASE_W-1:0] HAZ_LAST  = 2'd1;

  // Priority decode: hazard (or both turn switches) beats a single turn switch
  function automatic req_e decode_req(input logic haz, input logic left, input logic right);
    req_e req;
    if (haz || (left && right)) req = REQ_HAZ;
    else if (left)              req = REQ_L;
    else if (right)             req = REQ_R;
    else                        req = REQ_NONE;
    return req;
  endfunction

  // State entered when acting on a request
  function automatic state_e req_state(input req_e req);
    state_e st;
    case (req)
      REQ_HAZ: st = HAZARDS;
      REQ_L:   st = TURN_LEFT;
      REQ_R:   st = TURN_RIGHT;
      default: st = IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/taillight_sequencer_tick_prescaler.sv
// Blink prescaler: registered one-clk strobe once every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..TICK_DIV-1; strobe is raised for the clock after the terminal count
  always_comb begin
    tick_d = (cnt_q == CNT_LAST);
    cnt_d  = tick_d ? '0 : cnt_q + CNT_W'(1);
  end

  // Counter and strobe registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/taillight_sequencer.sv
// Tail-light next-state controller. Turn sweeps always finish before the state
// changes unless hazards pre-empt them. Define SW_SYNC_EN to put a 2-flop
// synchronizer on each switch (adds 2 clk input latency).
module taillight_sequencer
  import taillight_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw_hazard,
  input  logic       sw_left,
  input  logic       sw_right,
  output logic [2:0] current_state,
  output logic       tick,
  output logic [1:0] phase
  , output logic     busy
);

  logic [2:0]         sw_s;     // {hazard, left, right} as seen by decode
  req_e               req;
  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifdef SW_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  // Two-stage synchronizer for asynchronous switch inputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw_hazard, sw_left, sw_right};
      sync2_q <= sync1_q;
    end
  end

  assign sw_s = sync2_q;
`else
  assign sw_s = {sw_hazard, sw_left, sw_right};
`endif

  assign req = decode_req(sw_s[2], sw_s[1], sw_s[0]);

  // Next state and phase; only a tick can advance the sequencer
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (tick) begin
      case (state_q)
        IDLE: begin
          state_d = req_state(req);
          phase_d = '0;
        end
        TURN_LEFT, TURN_RIGHT: begin
          if (req == REQ_HAZ) begin
            state_d = HAZARDS;
            phase_d = '0;
          end else if (phase_q == TURN_LAST) begin
            state_d = req_state(req);
            phase_d = '0;
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
        HAZARDS: begin
          if (req != REQ_HAZ && phase_q == HAZ_LAST) begin
            state_d = req_state(req);
            phase_d = '0;
          end else begin
            phase_d = (phase_q == HAZ_LAST) ? '0 : HAZ_LAST;
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  // State and phase registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  assign current_state = state_q;
  assign phase         = phase_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_taillight_sequencer.sv
// Directed bench for taillight_sequencer with TICK_DIV=4, synchronous switches.
module tb_taillight_sequencer;

  logic       clk;
  logic       reset;
  logic       sw_hazard, sw_left, sw_right;
  logic [2:0] current_state;
  logic       tick;
  logic [1:0] phase;
  logic       busy;

  int checks = 0;
  int errors = 0;

  taillight_sequencer #(.TICK_DIV(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .sw_hazard     (sw_hazard),
    .sw_left       (sw_left),
    .sw_right      (sw_right),
    .current_state (current_state),
    .tick          (tick),
    .phase         (phase),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to the next negedge where tick is high; n = negedges waited
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 20);
    if (tick !== 1'b1) chk("tick_timeout", 32'(tick), 1);
  endtask

  // Let one tick act on the FSM, then sample after the updating edge
  task automatic adv();
    int n;
    wait_tick(n);
    @(negedge clk);
  endtask

  task automatic expect_st(input string tag, input int st, input int ph);
    chk({tag, "_state"}, 32'(current_state), st);
    chk({tag, "_phase"}, 32'(phase), ph);
    chk({tag, "_busy"},  32'(busy), (st != 0) ? 1 : 0);
  endtask

  initial begin
    int n;
    sw_hazard = 1'b0;
    sw_left   = 1'b0;
    sw_right  = 1'b0;
    reset     = 1'b0;
    #1 reset  = 1'b1;
    repeat (3) @(negedge clk);
    expect_st("in_reset", 0, 0);
    chk("in_reset_tick", 32'(tick), 0);

    // Release and measure tick spacing
    reset = 1'b0;
    wait_tick(n);
    chk("first_tick_lat", n, 4);
    expect_st("idle_first_tick", 0, 0);
    wait_tick(n);
    chk("tick_period", n, 4);
    @(negedge clk);
    chk("tick_one_clk", 32'(tick), 0);
    expect_st("idle_none", 0, 0);

    // Left sweep
    sw_left = 1'b1;
    adv(); expect_st("left_enter", 2, 0);
    adv(); expect_st("left_p1", 2, 1);
    adv(); expect_st("left_p2", 2, 2);
    adv(); expect_st("left_p3", 2, 3);
    adv(); expect_st("left_wrap", 2, 0);
    adv(); expect_st("left_p1b", 2, 1);

    // Direction change waits for sweep end
    sw_left  = 1'b0;
    sw_right = 1'b1;
    adv(); expect_st("chg_p2", 2, 2);
    adv(); expect_st("chg_p3", 2, 3);
    adv(); expect_st("right_enter", 3, 0);
    adv(); expect_st("right_p1", 3, 1);
    adv(); expect_st("right_p2", 3, 2);

    // Hazard pre-empts mid-sweep
    sw_hazard = 1'b1;
    adv(); expect_st("haz_enter", 1, 0);
    adv(); expect_st("haz_p1", 1, 1);
    adv(); expect_st("haz_p0", 1, 0);
    adv(); expect_st("haz_p1b", 1, 1);
    adv(); expect_st("haz_p0b", 1, 0);

    // Hazard release finishes the blink pair first
    sw_hazard = 1'b0;
    sw_right  = 1'b0;
    adv(); expect_st("haz_rel_p1", 1, 1);
    adv(); expect_st("haz_rel_idle", 0, 0);

    // Both turn switches count as hazard
    sw_left  = 1'b1;
    sw_right = 1'b1;
    adv(); expect_st("both_haz", 1, 0);

    // Async reset between ticks
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    expect_st("async_rst", 0, 0);
    sw_left  = 1'b0;
    sw_right = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wait_tick(n);
    chk("rst_tick_lat", n, 4);

    // Switch pulse between ticks is not seen
    @(negedge clk);
    sw_left = 1'b1;
    @(negedge clk);
    sw_left = 1'b0;
    adv(); expect_st("glitch_ignored", 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
